uiip_arp_tx: RTL and testbench

Transmit-side counterpart of the IP/ARP receive demux. It arbitrates between the IP transmit engine and the ARP transmit engine and wins one frame at a time from the MAC transmitter. It then forwards the granted byte stream to the MAC together with the EtherType and destination MAC. It sits between the uiip_ip_tx/uiip_arp_tx engines and the uimac_tx block.

---
 rtl/uiip_pkg.sv | 27 ++
 rtl/uiip_tx_rr2.sv | 37 +++
 rtl/uiip_arp_tx.sv | 185 ++++++++++++++++++
 tb/tb_uiip_arp_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uiip_pkg.sv
// Shared definitions for the uiip IP/ARP transmit and receive paths.
package uiip_pkg;

  localparam int unsigned MAC_W  = 48;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TYPE_W = 16;
  localparam int unsigned TCNT_W = 16;
  localparam int unsigned GCNT_W = 8;

  localparam logic [TYPE_W-1:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [TYPE_W-1:0] ETH_TYPE_ARP = 16'h0806;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_XFER,
    ST_GAP
  } tx_state_e;

  // Frame header handed to the MAC alongside the byte stream.
  typedef struct packed {
    logic [TYPE_W-1:0] eth_type;
    logic [MAC_W-1:0]  dest_mac;
  } tx_hdr_t;

endpackage

// File: rtl/uiip_tx_rr2.sv
// Two-input alternating-priority arbiter (IP vs ARP) with a last-winner register.
module uiip_tx_rr2
  import uiip_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_ip_i,
  input  logic req_arp_i,
  input  logic update_i,
  output logic win_arp_c_o,
  output logic any_req_c_o
);

  logic last_arp_q, last_arp_d;
  logic win_arp_c;

  // ARP takes a tie unless it won the previous arbitration.
  assign win_arp_c   = req_arp_i & (~req_ip_i | ~last_arp_q);
  assign win_arp_c_o = win_arp_c;
  assign any_req_c_o = req_ip_i | req_arp_i;

  always_comb begin
    last_arp_d = last_arp_q;
    if (update_i && (req_ip_i || req_arp_i)) begin
      last_arp_d = win_arp_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_arp_q <= 1'b0;
    end else begin
      last_arp_q <= last_arp_d;
    end
  end

endmodule

// File: rtl/uiip_arp_tx.sv
// Arbitrates IP and ARP transmit engines onto the MAC transmitter, one frame at a time,
// forwarding the winner's bytes with one cycle of latency plus its EtherType and destination.
module uiip_arp_tx
  import uiip_pkg::*;
#(
  parameter int unsigned GRANT_TIMEOUT = 255,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic                I_ip_arp_tclk,
  input  logic                I_ip_arp_reset_n,
  input  logic                I_ip_treq,
  output logic                O_ip_tgrant,
  input  logic                I_ip_tvalid,
  input  logic [BYTE_W-1:0]   I_ip_tdata,
  input  logic [MAC_W-1:0]    I_ip_tdest_mac,
  input  logic                I_arp_treq,
  output logic                O_arp_tgrant,
  input  logic                I_arp_tvalid,
  input  logic [BYTE_W-1:0]   I_arp_tdata,
  input  logic [MAC_W-1:0]    I_arp_tdest_mac,
  output logic                O_mac_treq,
  input  logic                I_mac_tack,
  output logic                O_mac_tvalid,
  output logic [BYTE_W-1:0]   O_mac_tdata,
  output logic [TYPE_W-1:0]   O_mac_tdata_type,
  output logic [MAC_W-1:0]    O_mac_tdest_mac,
  output logic                O_tx_abort
);

  // With no gap configured a finished frame returns straight to arbitration.
  localparam tx_state_e END_ST = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  tx_state_e           state_q, state_d;
  logic                win_arp_q, win_arp_d;
  tx_hdr_t             hdr_q, hdr_d;
  logic                mac_treq_q, mac_treq_d;
  logic                ip_tgrant_q, ip_tgrant_d;
  logic                arp_tgrant_q, arp_tgrant_d;
  logic                mac_tvalid_q, mac_tvalid_d;
  logic [BYTE_W-1:0]   mac_tdata_q, mac_tdata_d;
  logic                abort_q, abort_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;

  logic                arb_update_c;
  logic                arb_win_arp_c;
  logic                arb_any_req_c;
  logic                win_tvalid_c;
  logic [BYTE_W-1:0]   win_tdata_c;

  uiip_tx_rr2 u_rr2 (
    .clk         (I_ip_arp_tclk),
    .rst_n       (I_ip_arp_reset_n),
    .req_ip_i    (I_ip_treq),
    .req_arp_i   (I_arp_treq),
    .update_i    (arb_update_c),
    .win_arp_c_o (arb_win_arp_c),
    .any_req_c_o (arb_any_req_c)
  );

  // Only the granted source's byte stream is ever looked at.
  assign win_tvalid_c = win_arp_q ? I_arp_tvalid : I_ip_tvalid;
  assign win_tdata_c  = win_arp_q ? I_arp_tdata  : I_ip_tdata;

  always_comb begin
    state_d      = state_q;
    win_arp_d    = win_arp_q;
    hdr_d        = hdr_q;
    mac_treq_d   = mac_treq_q;
    ip_tgrant_d  = ip_tgrant_q;
    arp_tgrant_d = arp_tgrant_q;
    mac_tvalid_d = 1'b0;
    mac_tdata_d  = '0;
    abort_d      = 1'b0;
    tcnt_d       = tcnt_q;
    gcnt_d       = gcnt_q;
    arb_update_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any_req_c) begin
          arb_update_c = 1'b1;
          win_arp_d    = arb_win_arp_c;
          mac_treq_d   = 1'b1;
          state_d      = ST_REQ;
          if (arb_win_arp_c) begin
            hdr_d.eth_type = ETH_TYPE_ARP;
            hdr_d.dest_mac = I_arp_tdest_mac;
          end else begin
            hdr_d.eth_type = ETH_TYPE_IP;
            hdr_d.dest_mac = I_ip_tdest_mac;
          end
        end
      end

      ST_REQ: begin
        if (I_mac_tack) begin
          mac_treq_d   = 1'b0;
          ip_tgrant_d  = ~win_arp_q;
          arp_tgrant_d = win_arp_q;
          tcnt_d       = '0;
          state_d      = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (win_tvalid_c) begin
          mac_tvalid_d = 1'b1;
          mac_tdata_d  = win_tdata_c;
          state_d      = ST_XFER;
        end else if (tcnt_q >= TCNT_W'(GRANT_TIMEOUT - 1)) begin
          abort_d      = 1'b1;
          ip_tgrant_d  = 1'b0;
          arp_tgrant_d = 1'b0;
          gcnt_d       = '0;
          state_d      = END_ST;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_XFER: begin
        if (win_tvalid_c) begin
          mac_tvalid_d = 1'b1;
          mac_tdata_d  = win_tdata_c;
        end else begin
          ip_tgrant_d  = 1'b0;
          arp_tgrant_d = 1'b0;
          gcnt_d       = '0;
          state_d      = END_ST;
        end
      end

      ST_GAP: begin
        if (gcnt_q >= GCNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_ip_arp_tclk or negedge I_ip_arp_reset_n) begin
    if (!I_ip_arp_reset_n) begin
      state_q      <= ST_IDLE;
      win_arp_q    <= 1'b0;
      hdr_q        <= '0;
      mac_treq_q   <= 1'b0;
      ip_tgrant_q  <= 1'b0;
      arp_tgrant_q <= 1'b0;
      mac_tvalid_q <= 1'b0;
      mac_tdata_q  <= '0;
      abort_q      <= 1'b0;
      tcnt_q       <= '0;
      gcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      win_arp_q    <= win_arp_d;
      hdr_q        <= hdr_d;
      mac_treq_q   <= mac_treq_d;
      ip_tgrant_q  <= ip_tgrant_d;
      arp_tgrant_q <= arp_tgrant_d;
      mac_tvalid_q <= mac_tvalid_d;
      mac_tdata_q  <= mac_tdata_d;
      abort_q      <= abort_d;
      tcnt_q       <= tcnt_d;
      gcnt_q       <= gcnt_d;
    end
  end

  assign O_ip_tgrant      = ip_tgrant_q;
  assign O_arp_tgrant     = arp_tgrant_q;
  assign O_mac_treq       = mac_treq_q;
  assign O_mac_tvalid     = mac_tvalid_q;
  assign O_mac_tdata      = mac_tdata_q;
  assign O_mac_tdata_type = hdr_q.eth_type;
  assign O_mac_tdest_mac  = hdr_q.dest_mac;
  assign O_tx_abort       = abort_q;

endmodule

// File: tb/tb_uiip_arp_tx.sv
// Directed bench for uiip_arp_tx: arbitration order, byte forwarding, gap, timeout and reset.
module tb_uiip_arp_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        I_ip_treq, I_ip_tvalid, I_arp_treq, I_arp_tvalid, I_mac_tack;
  logic [7:0]  I_ip_tdata, I_arp_tdata;
  logic [47:0] I_ip_tdest_mac, I_arp_tdest_mac;
  logic        O_ip_tgrant, O_arp_tgrant, O_mac_treq, O_mac_tvalid, O_tx_abort;
  logic [7:0]  O_mac_tdata;
  logic [15:0] O_mac_tdata_type;
  logic [47:0] O_mac_tdest_mac;

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] DEST_IP   = 48'h001122334455;
  localparam logic [47:0] DEST_BC   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] DEST_ARP2 = 48'h0A0B0C0D0E0F;

  always #5 clk = ~clk;

  uiip_arp_tx #(.GRANT_TIMEOUT(8), .GAP_CYCLES(2)) dut (
    .I_ip_arp_tclk    (clk),
    .I_ip_arp_reset_n (rst_n),
    .I_ip_treq        (I_ip_treq),
    .O_ip_tgrant      (O_ip_tgrant),
    .I_ip_tvalid      (I_ip_tvalid),
    .I_ip_tdata       (I_ip_tdata),
    .I_ip_tdest_mac   (I_ip_tdest_mac),
    .I_arp_treq       (I_arp_treq),
    .O_arp_tgrant     (O_arp_tgrant),
    .I_arp_tvalid     (I_arp_tvalid),
    .I_arp_tdata      (I_arp_tdata),
    .I_arp_tdest_mac  (I_arp_tdest_mac),
    .O_mac_treq       (O_mac_treq),
    .I_mac_tack       (I_mac_tack),
    .O_mac_tvalid     (O_mac_tvalid),
    .O_mac_tdata      (O_mac_tdata),
    .O_mac_tdata_type (O_mac_tdata_type),
    .O_mac_tdest_mac  (O_mac_tdest_mac),
    .O_tx_abort       (O_tx_abort)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_treq"},   O_mac_treq,       0);
    chk({tag, "_ipg"},    O_ip_tgrant,      0);
    chk({tag, "_arpg"},   O_arp_tgrant,     0);
    chk({tag, "_tvalid"}, O_mac_tvalid,     0);
    chk({tag, "_tdata"},  O_mac_tdata,      0);
    chk({tag, "_type"},   O_mac_tdata_type, 0);
    chk({tag, "_dest"},   O_mac_tdest_mac,  0);
    chk({tag, "_abort"},  O_tx_abort,       0);
  endtask

  // Drives n bytes base..base+n-1 from the winner, checks the MAC copy one cycle later.
  task automatic stream(input bit arp, input int n, input logic [7:0] base, input bit toggle);
    logic [7:0] e;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        e = base + 8'(i - 1);
        chk("x_tvalid", O_mac_tvalid, 1);
        chk("x_tdata",  O_mac_tdata,  e);
        chk("x_grant",  arp ? O_arp_tgrant : O_ip_tgrant, 1);
      end
      if (arp) begin
        I_arp_tvalid = (i < n);
        I_arp_tdata  = (i < n) ? base + 8'(i) : 8'h00;
      end else begin
        I_ip_tvalid = (i < n);
        I_ip_tdata  = (i < n) ? base + 8'(i) : 8'h00;
        if (toggle) begin
          I_arp_tvalid = ~I_arp_tvalid;
          I_arp_tdata  = 8'hEE;
        end
      end
      @(negedge clk);
    end
    I_arp_tvalid = 1'b0;
    I_arp_tdata  = 8'h00;
    chk("end_grant",  arp ? O_arp_tgrant : O_ip_tgrant, 0);
    chk("end_tvalid", O_mac_tvalid, 0);
    chk("end_tdata",  O_mac_tdata,  0);
  endtask

  // Expects O_mac_treq exactly wait_cyc cycles from now, acks after ack_delay, then streams.
  task automatic serve(input bit arp, input logic [47:0] dest, input int wait_cyc,
                       input int ack_delay, input int n, input logic [7:0] base,
                       input bit toggle);
    repeat (wait_cyc - 1) begin
      @(negedge clk);
      chk("gap_treq", O_mac_treq, 0);
    end
    @(negedge clk);
    chk("req_treq", O_mac_treq, 1);
    chk("req_type", O_mac_tdata_type, arp ? 16'h0806 : 16'h0800);
    chk("req_dest", O_mac_tdest_mac, dest);
    repeat (ack_delay) begin
      @(negedge clk);
      chk("hold_treq",  O_mac_treq, 1);
      chk("hold_grant", O_ip_tgrant | O_arp_tgrant, 0);
    end
    I_mac_tack = 1'b1;
    @(negedge clk);
    I_mac_tack = 1'b0;
    chk("ack_treq",  O_mac_treq,   0);
    chk("ack_win",   arp ? O_arp_tgrant : O_ip_tgrant, 1);
    chk("ack_lose",  arp ? O_ip_tgrant : O_arp_tgrant, 0);
    if (arp) I_arp_treq = 1'b0;
    else     I_ip_treq  = 1'b0;
    stream(arp, n, base, toggle);
  endtask

  // Both grants must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("grant_mutex", O_ip_tgrant & O_arp_tgrant, 0);
  end

  initial begin
    rst_n = 1'b0;
    I_ip_treq = 0; I_ip_tvalid = 0; I_ip_tdata = 0; I_ip_tdest_mac = DEST_IP;
    I_arp_treq = 0; I_arp_tvalid = 0; I_arp_tdata = 0; I_arp_tdest_mac = DEST_BC;
    I_mac_tack = 0;
    #1;
    chk_all_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous pair after reset: ARP first, then IP, twice.
    I_ip_treq = 1'b1; I_arp_treq = 1'b1; I_arp_tdest_mac = DEST_ARP2;
    serve(1'b1, DEST_ARP2, 1, 0, 4, 8'h10, 1'b0);
    serve(1'b0, DEST_IP,   3, 0, 4, 8'h20, 1'b0);
    I_ip_treq = 1'b1; I_arp_treq = 1'b1;
    serve(1'b1, DEST_ARP2, 3, 1, 3, 8'h50, 1'b0);
    serve(1'b0, DEST_IP,   3, 0, 3, 8'h60, 1'b0);
    repeat (3) @(negedge clk);

    // IP only, ack after 3 cycles, 46 bytes; then ARP broadcast served after the gap.
    I_ip_treq = 1'b1; I_ip_tdest_mac = DEST_IP;
    serve(1'b0, DEST_IP, 1, 3, 46, 8'h00, 1'b0);
    I_arp_treq = 1'b1; I_arp_tdest_mac = DEST_BC;
    serve(1'b1, DEST_BC, 3, 0, 28, 8'h40, 1'b0);
    repeat (3) @(negedge clk);

    // Grant timeout: IP granted but never sends.
    I_ip_treq = 1'b1;
    @(negedge clk);
    chk("to_treq", O_mac_treq, 1);
    I_mac_tack = 1'b1;
    @(negedge clk);
    I_mac_tack = 1'b0;
    I_ip_treq  = 1'b0;
    chk("to_grant0", O_ip_tgrant, 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("to_abort",  O_tx_abort,  (k == 8));
      chk("to_grant",  O_ip_tgrant, (k < 8));
      chk("to_tvalid", O_mac_tvalid, 0);
    end
    repeat (3) @(negedge clk);

    // ARP tvalid toggling while IP owns the path.
    I_ip_treq = 1'b1;
    serve(1'b0, DEST_IP, 1, 0, 16, 8'h80, 1'b1);
    repeat (3) @(negedge clk);

    // Reset mid-frame at byte 10, then a fresh ARP request.
    I_ip_treq = 1'b1;
    @(negedge clk);
    chk("mr_treq", O_mac_treq, 1);
    I_mac_tack = 1'b1;
    @(negedge clk);
    I_mac_tack = 1'b0;
    I_ip_treq  = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) chk("mr_tdata", O_mac_tdata, 8'(i - 1));
      I_ip_tvalid = 1'b1;
      I_ip_tdata  = 8'(i);
      if (i < 10) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mrst");
    I_ip_tvalid = 1'b0;
    I_ip_tdata  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    I_arp_treq = 1'b1; I_arp_tdest_mac = DEST_BC;
    serve(1'b1, DEST_BC, 1, 1, 8, 8'h30, 1'b0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
